// File: rtl/lc3b_types.sv
// Shared LC-3b type package.
//   lc3b_word      : 16-bit machine word
//   lc3b_mem_wmask : 2-bit byte-enable mask (bit0 -> [7:0], bit1 -> [15:8])
//   lc3b_mem_seed  : reset seed of the optional stall LFSR in the memory responder
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    localparam logic [3:0] lc3b_mem_seed = 4'b1001;
endpackage

// File: rtl/mem_array.sv
// Word storage for the LC-3b memory responder.
// 2^ADDR_BITS x 16-bit words held as two byte lanes so that each byte can be
// written independently. Read is combinational; the caller registers it.
// Ports:
//   clk   : clock, rising edge
//   addr  : word index (shared by read and write)
//   we    : write strobe
//   be    : byte enables for the write
//   wdata : write data
//   rdata : combinational read of addr
module mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 we,
    input  lc3b_mem_wmask        be,
    input  lc3b_word             wdata,
    output lc3b_word             rdata
);
    localparam int DEPTH = 1 << ADDR_BITS;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane_mem[addr];
        end
    endgenerate
endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: accepts a held mem_read/mem_write request, waits a
// programmable latency, performs the access on an internal word array and
// pulses mem_resp for one cycle with the read data.
// Optional build macro: LC3B_MEM_RANDOM_STALL_EN adds a 0..3 cycle stall per
// accepted request taken from a 4-bit LFSR (x^4+x^3+1).
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   mem_read        : read request, held until mem_resp
//   mem_write       : write request, held until mem_resp (wins over read)
//   mem_byte_enable : byte enables for writes
//   mem_address     : byte address; word index is mem_address[ADDR_BITS:1]
//   mem_wdata       : write data
//   mem_rdata       : read data, valid while mem_resp=1
//   mem_resp        : single-cycle completion pulse
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    output lc3b_word      mem_rdata,
    output logic          mem_resp
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

    state_t               state_reg;
    logic                 op_write_reg;
    logic [ADDR_BITS-1:0] index_reg;
    lc3b_word             wdata_reg;
    lc3b_mem_wmask        be_reg;
    logic [7:0]           count_reg;

    logic [7:0]           load_value;
    logic                 req_held;
    logic [ADDR_BITS-1:0] array_addr;
    logic                 array_we;
    lc3b_word             array_rdata;

    // Byte offset and high address bits are don't-care: addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[0], mem_address[15:ADDR_BITS+1]};

`ifdef LC3B_MEM_RANDOM_STALL_EN
    logic [3:0] lfsr_reg;
    logic [3:0] lfsr_next;
    assign lfsr_next = {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
`endif

    always_comb begin
        load_value = mem_write ? WR_LOAD : RD_LOAD;
`ifdef LC3B_MEM_RANDOM_STALL_EN
        load_value = load_value + {6'd0, lfsr_reg[1:0]};
`endif
    end

    // The request that was accepted must stay asserted while waiting.
    assign req_held = op_write_reg ? mem_write : mem_read;

    // In IDLE the array is looked up with the live address so a zero-wait
    // access can capture read data on the accepting edge.
    assign array_addr = (state_reg == IDLE) ? mem_address[ADDR_BITS:1] : index_reg;

    // Write lands on the edge that ends RESP, unless reset is asserted then.
    assign array_we = (state_reg == RESP) && op_write_reg && !rst;

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk   (clk),
        .addr  (array_addr),
        .we    (array_we),
        .be    (be_reg),
        .wdata (wdata_reg),
        .rdata (array_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mem_resp  <= 1'b0;
            mem_rdata <= 16'h0000;
            count_reg <= 8'd0;
`ifdef LC3B_MEM_RANDOM_STALL_EN
            lfsr_reg  <= lc3b_mem_seed;
`endif
        end else begin
            mem_resp <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mem_write || mem_read) begin
                        op_write_reg <= mem_write;
                        index_reg    <= mem_address[ADDR_BITS:1];
                        wdata_reg    <= mem_wdata;
                        be_reg       <= mem_byte_enable;
                        count_reg    <= load_value;
`ifdef LC3B_MEM_RANDOM_STALL_EN
                        lfsr_reg     <= lfsr_next;
`endif
                        if (load_value == 8'd0) begin
                            state_reg <= RESP;
                            mem_resp  <= 1'b1;
                            mem_rdata <= array_rdata;
                        end else begin
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!req_held) begin
                        state_reg <= IDLE;
                        count_reg <= 8'd0;
                    end else begin
                        count_reg <= count_reg - 8'd1;
                        // Counter reaches 0 on this edge: respond next cycle.
                        if (count_reg == 8'd1) begin
                            state_reg <= RESP;
                            mem_resp  <= 1'b1;
                            mem_rdata <= array_rdata;
                        end
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lc3b_mem_responder.sv
module tb_lc3b_mem_responder;
    import lc3b_types::*;

    logic          clk;
    logic          rst;
    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_word      mem_rdata;
    logic          mem_resp;

    int tests_run;
    int tests_failed;

    lc3b_mem_responder dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rd;
        bit        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          exp_lat;
        bit          chk_rdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be,
                           input int exp_lat, input bit chk, input logic [15:0] exp_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_lat = exp_lat; v.chk_rdata = chk; v.exp_rdata = exp_rd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request #1 after an edge and wait for mem_resp (bounded).
    // lat = number of edges until mem_resp is seen, -1 on timeout.
    task automatic do_access(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [1:0] be,
                             output int lat, output logic [15:0] rdata);
        lat = -1;
        rdata = 16'hxxxx;
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = wdata;
        mem_byte_enable = be;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (mem_resp) begin
                lat = k;
                rdata = mem_rdata;
                break;
            end
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        check("resp_one_cycle", {31'd0, mem_resp}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [15:0] rdata;
        logic [7:0]  pattern;

        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address = 16'h0000;
        mem_wdata = 16'h0000;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_resp", {31'd0, mem_resp}, 32'd0);
        check("reset_rdata", {16'd0, mem_rdata}, 32'd0);

`ifndef LC3B_MEM_RANDOM_STALL_EN
        //       rd    wr    addr      wdata     be     lat chk exp_rdata
        add_vec(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 2, 0, 16'h0000);
        add_vec(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 3, 1, 16'hBEEF);
        add_vec(1'b1, 1'b0, 16'h0011, 16'h0000, 2'b00, 3, 1, 16'hBEEF);
        add_vec(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 2, 0, 16'h0000);
        add_vec(1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 2, 0, 16'h0000);
        add_vec(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 3, 1, 16'hAB34);
        add_vec(1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, 2, 0, 16'h0000);
        add_vec(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 3, 1, 16'hABCD);
        add_vec(1'b0, 1'b1, 16'h0201, 16'h5A5A, 2'b11, 2, 0, 16'h0000);
        add_vec(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 3, 1, 16'h5A5A);
        add_vec(1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11, 2, 0, 16'h0000);
        add_vec(1'b0, 1'b1, 16'h0030, 16'hFFFF, 2'b00, 2, 0, 16'h0000);
        add_vec(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 3, 1, 16'h1111);
        add_vec(1'b0, 1'b1, 16'h0040, 16'h1357, 2'b11, 2, 0, 16'h0000);
        add_vec(1'b1, 1'b1, 16'h0040, 16'h7777, 2'b11, 2, 1, 16'h1357);
        add_vec(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 3, 1, 16'h7777);

        foreach (vecs[i]) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].be, lat, rdata);
            $display("[TB] vec %0d rd=%0b wr=%0b addr=%h wdata=%h be=%b lat=%0d rdata=%h",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     vecs[i].be, lat, rdata);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].chk_rdata)
                check($sformatf("vec%0d_rdata", i), {16'd0, rdata}, {16'd0, vecs[i].exp_rdata});
        end

        // Abort: write dropped the cycle after acceptance.
        do_access(1'b0, 1'b1, 16'h0050, 16'h1111, 2'b11, lat, rdata);
        check("abort_setup_latency", 32'(lat), 32'd2);
        mem_write = 1'b1;
        mem_address = 16'h0050;
        mem_wdata = 16'h2222;
        mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        mem_write = 1'b0;
        pattern = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            pattern[k] = mem_resp;
        end
        $display("[TB] abort write resp_pattern=%b", pattern);
        check("abort_no_resp", {24'd0, pattern}, 32'd0);
        do_access(1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, lat, rdata);
        $display("[TB] read after abort lat=%0d rdata=%h", lat, rdata);
        check("abort_array_unchanged", {16'd0, rdata}, 32'h0000_1111);

        // Reset while BUSY: no response, rdata cleared.
        mem_read = 1'b1;
        mem_address = 16'h0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset in BUSY resp=%b rdata=%h", mem_resp, mem_rdata);
        check("rst_busy_resp", {31'd0, mem_resp}, 32'd0);
        check("rst_busy_rdata", {16'd0, mem_rdata}, 32'd0);
        rst = 1'b0;
        mem_read = 1'b0;
        @(posedge clk); #1;
        check("rst_busy_after_resp", {31'd0, mem_resp}, 32'd0);

        // Back-to-back: read held across RESP into a second read.
        mem_read = 1'b1;
        mem_address = 16'h0020;
        pattern = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            pattern[k-1] = mem_resp;
            if (k == 3) check("b2b_rdata_first", {16'd0, mem_rdata}, 32'h0000_ABCD);
            if (k == 7) begin
                check("b2b_rdata_second", {16'd0, mem_rdata}, 32'h0000_ABCD);
                mem_read = 1'b0;
            end
        end
        $display("[TB] back-to-back resp_pattern=%b", pattern);
        check("b2b_pattern", {24'd0, pattern}, 32'h0000_0044);
`else
        begin
            logic [3:0] model_lfsr;
            int         exp_lat;
            model_lfsr = 4'b1001;
            for (int i = 0; i < 16; i++) begin
                exp_lat = 3 + int'(model_lfsr[1:0]);
                if (i == 0) check("stall_first_latency", 32'(exp_lat), 32'd4);
                do_access(1'b1, 1'b0, 16'(i * 2), 16'h0000, 2'b00, lat, rdata);
                $display("[TB] stall read %0d lat=%0d expected=%0d", i, lat, exp_lat);
                check($sformatf("stall%0d_latency", i), 32'(lat), 32'(exp_lat));
                model_lfsr = {model_lfsr[2:0], model_lfsr[3] ^ model_lfsr[2]};
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/lc3b_mem_responder.md
# lc3b_mem_responder

Synthesizable memory responder for the LC-3b core's memory port. It receives `mem_read`/`mem_write` requests from the control/datapath, holds them for a programmable latency, then performs the access on an internal word array. It returns `mem_rdata` together with a one-cycle `mem_resp`. It serves as the memory model in the top-level bench and in FPGA bring-up.

## Interface
Parameters:
- `ADDR_BITS`, default 8: number of word-index bits; array depth is 2^ADDR_BITS 16-bit words.
- `READ_LATENCY`, default 3: cycles from request to `mem_resp` for reads; must be ≥1.
- `WRITE_LATENCY`, default 2: same, for writes; must be ≥1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `mem_read` in 1: read request, held by the initiator until `mem_resp`.
- `mem_write` in 1: write request, held by the initiator until `mem_resp`.
- `mem_byte_enable` in 2 (`lc3b_mem_wmask`): bit0 enables byte [7:0], bit1 enables byte [15:8]; writes only.
- `mem_address` in 16 (`lc3b_word`): byte address.
- `mem_wdata` in 16 (`lc3b_word`): write data.
- `mem_rdata` out 16 (`lc3b_word`): read data, valid while `mem_resp`=1.
- `mem_resp` out 1: single-cycle completion pulse.

## Operation
- FSM states: `IDLE`, `BUSY`, `RESP`.
- `IDLE`:
  - If `mem_write`=1, latch op=write, address, wdata and byte enable. Load the counter with `WRITE_LATENCY-1`.
  - Else if `mem_read`=1, latch op=read and address. Load the counter with `READ_LATENCY-1`.
  - Go to `RESP` if the loaded value is 0, otherwise go to `BUSY`.
- `BUSY`:
  - Decrement the counter each cycle; on reaching 0, go to `RESP`.
  - If the request latched in `IDLE` is deasserted, abort to `IDLE`: no access, no `mem_resp`.
- `RESP`:
  - `mem_resp`=1 for exactly one cycle, then return to `IDLE`.
  - Read: `mem_rdata` = array[index].
  - Write: at the edge ending `RESP`, write each enabled byte; disabled bytes are unchanged.
- Word index is `mem_address[ADDR_BITS:1]`. `mem_address[0]` and bits above `ADDR_BITS` are ignored, so out-of-range addresses alias (wrap).
- If `mem_read` and `mem_write` are both 1, the request is a write. `mem_rdata` then shows the pre-write word.
- Address and data are latched at request acceptance. Later changes to those inputs during `BUSY` are ignored.
- A write with `mem_byte_enable`=2'b00 still completes and responds, with no array change.

## Timing
- A request first high in cycle N produces `mem_resp`=1 in cycle N+LATENCY (READ or WRITE as applicable).
- `mem_resp` is never high in two consecutive cycles.
- The cycle after `RESP` is `IDLE`, and a request present then is accepted. Back-to-back accesses therefore cost LATENCY+1 cycles each.
- Reset values: state=`IDLE`, `mem_resp`=0, `mem_rdata`=16'h0000, counter=0.
- Array contents are not reset.
- Reset asserted mid-operation aborts the operation. No write occurs and no `mem_resp` is issued.
- A write whose response cycle coincides with `rst`=1 is discarded.

## Configuration
- `LC3B_MEM_RANDOM_STALL_EN`:
  - Defined: a 4-bit LFSR (x^4+x^3+1, reset seed 4'b1001) advances once per accepted request. Its low 2 bits (0–3) are added to the loaded latency, giving total latency LATENCY+stall.
  - Undefined: no LFSR; latency is fixed at the parameter values.

## Structure
- `lc3b_types` package provides `lc3b_word` and `lc3b_mem_wmask` (existing).
- New shared package constant: `lc3b_mem_seed` (4'b1001).
- The FSM state enum stays local to the module.
- One sub-module, `mem_array`: 2^ADDR_BITS × 16 storage with combinational read and byte-enabled synchronous write.
- The FSM, counter and optional LFSR live in `lc3b_mem_responder`.

## Test plan
All scenarios use the default parameters with `LC3B_MEM_RANDOM_STALL_EN` undefined, except scenario 6.
1. Write full word: write 16'hBEEF to 0x0010, enable 2'b11. `mem_resp` in cycle N+2. A read of 0x0010 then returns 16'hBEEF with `mem_resp` in cycle M+3.
2. Byte writes: write 16'h1234 to 0x0020 (2'b11), then 16'hAB00 with 2'b10. A read returns 16'hAB34. Write 16'h00CD with 2'b01; a read returns 16'hABCD.
3. Address alias and odd address: write 16'h5A5A to 0x0201. A read of 0x0000 returns 16'h5A5A (ADDR_BITS=8).
4. Abort and reset: drop `mem_write` in the cycle after acceptance. No `mem_resp` and the array is unchanged. Separately, assert `rst` during `BUSY`: `mem_resp`=0 and `mem_rdata`=0 the next cycle.
5. Back-to-back: a read held across `RESP` into a new read gives `mem_resp` in cycles N+3 and N+7, each one cycle wide.
6. Random stall, macro defined: first accepted read has total latency 3+(4'b1001 & 3)=4. The latency over 16 requests matches a reference LFSR model.
